// File: rtl/stage_sequencer.sv
// Core stage sequencer: owns the program-load handshake, then cycles
// FETCH/DECODE/EXECUTE with run/halt, single-step, reload and a retired counter.
module stage_sequencer #(
  parameter int PMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              step,
  input  logic              reload,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_addr,
  output logic              pmem_load_we,
  output logic              pc_clr,
  output logic [1:0]        stage,
  output logic              halted,
  output logic              load_done,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_DECODE, S_EXECUTE, S_HALT
  } state_t;

  state_t state, state_nx;
  logic   step_pending;
  logic   load_beat, load_term, enter_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign load_beat  = (state == S_LOAD) && load_valid;
  assign load_term  = load_beat && (load_last || (load_addr == ADDR_W'(PMEM_DEPTH - 1)));
  assign enter_load = (state_nx == S_LOAD) && (state != S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:    if (load_term) state_nx = run_en ? S_FETCH : S_HALT;
      S_FETCH:   state_nx = S_DECODE;
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: begin
        if (reload)            state_nx = S_LOAD;
        else if (step_pending) state_nx = S_HALT;
        else if (!run_en)      state_nx = S_HALT;
        else                   state_nx = S_FETCH;
      end
      S_HALT: begin
        if (reload)      state_nx = S_LOAD;
        else if (run_en) state_nx = S_FETCH;
        else if (step)   state_nx = S_FETCH;
      end
      default:   state_nx = S_LOAD;
    endcase
  end

  always_comb begin
    load_ready   = (state == S_LOAD);
    pmem_load_we = load_valid && (state == S_LOAD);
    pc_clr       = load_term;
    halted       = (state == S_HALT);
    case (state)
      S_LOAD:    stage = 2'b00;
      S_FETCH:   stage = 2'b01;
      S_DECODE:  stage = 2'b10;
      S_EXECUTE: stage = 2'b11;
      S_HALT:    stage = 2'b01;
      default:   stage = 2'b00;
    endcase
  end

  // Load bookkeeping, retired counter and the one-shot step flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_addr    <= '0;
      load_done    <= 1'b0;
      instr_count  <= '0;
      step_pending <= 1'b0;
    end else begin
      if (load_term || enter_load) load_addr <= '0;
      else if (load_beat)          load_addr <= load_addr + ADDR_W'(1);

      if (load_term)       load_done <= 1'b1;
      else if (enter_load) load_done <= 1'b0;

      if (state == S_EXECUTE) instr_count <= sat_inc(instr_count);

      if (state == S_EXECUTE)
        step_pending <= 1'b0;
      else if (state == S_HALT && !reload && !run_en && step)
        step_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: load, auto-terminate, halt/step, reload,
// async reset and counter saturation with an address scoreboard.
module tb_stage_sequencer;
  localparam int PMEM_DEPTH = 8;
  localparam int ADDR_W     = 8;
  localparam int CNT_W      = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_en = 1'b0, step = 1'b0, reload = 1'b0;
  logic              load_valid = 1'b0, load_last = 1'b0;
  logic              load_ready, pmem_load_we, pc_clr, halted, load_done;
  logic [ADDR_W-1:0] load_addr;
  logic [1:0]        stage;
  logic [CNT_W-1:0]  instr_count;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] addr_q[$];
  logic [ADDR_W-1:0] exp_addr;

  stage_sequencer #(.PMEM_DEPTH(PMEM_DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .step(step), .reload(reload),
    .load_valid(load_valid), .load_last(load_last), .load_ready(load_ready),
    .load_addr(load_addr), .pmem_load_we(pmem_load_we), .pc_clr(pc_clr),
    .stage(stage), .halted(halted), .load_done(load_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run_en = 1'b0; step = 1'b0; reload = 1'b0;
    load_valid = 1'b0; load_last = 1'b0;
    addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_one(input logic run);
    @(negedge clk);
    run_en = run; load_valid = 1'b1; load_last = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; run_en = 1'b1; load_valid = 1'b0;
    #1;
    checks++; if (stage !== 2'b00) begin errors++; $display("FAIL reset_stage got %0h exp 0", stage); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", load_ready); end
    checks++; if (halted !== 1'b0 || load_done !== 1'b0 || pc_clr !== 1'b0 || pmem_load_we !== 1'b0) begin
      errors++; $display("FAIL reset_flags got h%0b d%0b c%0b w%0b exp all 0", halted, load_done, pc_clr, pmem_load_we); end
    checks++; if (instr_count !== '0 || load_addr !== '0) begin
      errors++; $display("FAIL reset_counts got cnt %0d addr %0d exp 0 0", instr_count, load_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [1:0] exp_stage[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    do_reset();
    run_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_last = (i == 3);
      addr_q.push_back(ADDR_W'(i));
      #1;
      checks++; if (pmem_load_we !== 1'b1) begin errors++; $display("FAIL load_we beat %0d got %0b exp 1", i, pmem_load_we); end
      if (pmem_load_we === 1'b1 && addr_q.size() > 0) begin
        exp_addr = addr_q.pop_front();
        checks++; if (load_addr !== exp_addr) begin errors++; $display("FAIL load_addr got %0d exp %0d", load_addr, exp_addr); end
      end
      checks++; if (pc_clr !== (i == 3)) begin errors++; $display("FAIL load_pc_clr beat %0d got %0b exp %0b", i, pc_clr, (i == 3)); end
      checks++; if (stage !== 2'b00) begin errors++; $display("FAIL load_stage got %0h exp 0", stage); end
      @(negedge clk);
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL load_queue got %0d left exp 0", addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stage !== exp_stage[i]) begin errors++; $display("FAIL load_seq %0d got %0h exp %0h", i, stage, exp_stage[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (load_done !== 1'b1 || load_addr !== '0) begin
      errors++; $display("FAIL load_done got d%0b addr %0d exp 1 0", load_done, load_addr); end
  endtask

  task automatic test_autoterm();
    do_reset();
    run_en = 1'b1;
    for (int i = 0; i < PMEM_DEPTH; i++) begin
      load_valid = 1'b1; load_last = 1'b0;
      addr_q.push_back(ADDR_W'(i));
      #1;
      if (pmem_load_we === 1'b1 && addr_q.size() > 0) begin
        exp_addr = addr_q.pop_front();
        checks++; if (load_addr !== exp_addr) begin errors++; $display("FAIL auto_addr got %0d exp %0d", load_addr, exp_addr); end
      end
      checks++; if (pc_clr !== (i == PMEM_DEPTH - 1)) begin
        errors++; $display("FAIL auto_pc_clr beat %0d got %0b exp %0b", i, pc_clr, (i == PMEM_DEPTH - 1)); end
      @(negedge clk);
    end
    load_valid = 1'b0;
    #1;
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL auto_queue got %0d left exp 0", addr_q.size()); end
    checks++; if (stage !== 2'b01 || load_ready !== 1'b0 || load_addr !== '0) begin
      errors++; $display("FAIL auto_exit got st %0h rdy %0b addr %0d exp 1 0 0", stage, load_ready, load_addr); end
  endtask

  task automatic test_halt_step();
    do_reset();
    load_one(1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int s = 1; s <= 3; s++) begin
        #1;
        checks++; if (stage !== 2'(s)) begin errors++; $display("FAIL run_stage i%0d got %0h exp %0h", k, stage, s); end
        if (s == 1) begin
          checks++; if (instr_count !== CNT_W'(k)) begin errors++; $display("FAIL run_count got %0d exp %0d", instr_count, k); end
        end
        if (k == 4 && s == 2) run_en = 1'b0;
        @(negedge clk);
      end
    end
    #1;
    checks++; if (halted !== 1'b1 || stage !== 2'b01 || instr_count !== CNT_W'(5)) begin
      errors++; $display("FAIL halt got h%0b st %0h cnt %0d exp 1 1 5", halted, stage, instr_count); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold got %0b exp 1", halted); end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      #1;
      checks++; if (stage !== 2'(s) || halted !== 1'b0) begin
        errors++; $display("FAIL step_stage got %0h h%0b exp %0h 0", stage, halted, s); end
      @(negedge clk);
    end
    #1;
    checks++; if (halted !== 1'b1 || instr_count !== CNT_W'(6)) begin
      errors++; $display("FAIL step_done got h%0b cnt %0d exp 1 6", halted, instr_count); end
    @(negedge clk);
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_once got %0b exp 1", halted); end
  endtask

  task automatic test_reload();
    logic v[3] = '{1'b1, 1'b0, 1'b1};
    int na;
    do_reset();
    load_one(1'b1);
    #1;
    checks++; if (stage !== 2'b01 || load_done !== 1'b1) begin
      errors++; $display("FAIL rl_pre got st %0h d%0b exp 1 1", stage, load_done); end
    reload = 1'b1;
    @(negedge clk); #1;
    checks++; if (stage !== 2'b10) begin errors++; $display("FAIL rl_dec got %0h exp 2", stage); end
    @(negedge clk); #1;
    checks++; if (stage !== 2'b11) begin errors++; $display("FAIL rl_exe got %0h exp 3", stage); end
    @(negedge clk); #1;
    checks++; if (stage !== 2'b00 || load_ready !== 1'b1 || load_done !== 1'b0 || load_addr !== '0) begin
      errors++; $display("FAIL rl_load got st %0h r%0b d%0b a%0d exp 0 1 0 0", stage, load_ready, load_done, load_addr); end
    na = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = v[i]; load_last = (i == 2);
      if (i == 2) reload = 1'b0;
      if (v[i]) begin addr_q.push_back(ADDR_W'(na)); na++; end
      #1;
      checks++; if (pmem_load_we !== v[i]) begin errors++; $display("FAIL gap_we %0d got %0b exp %0b", i, pmem_load_we, v[i]); end
      if (pmem_load_we === 1'b1 && addr_q.size() > 0) begin
        exp_addr = addr_q.pop_front();
        checks++; if (load_addr !== exp_addr) begin errors++; $display("FAIL gap_addr got %0d exp %0d", load_addr, exp_addr); end
      end
      checks++; if (pc_clr !== (i == 2)) begin errors++; $display("FAIL gap_pc_clr %0d got %0b exp %0b", i, pc_clr, (i == 2)); end
      @(negedge clk);
    end
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    checks++; if (stage !== 2'b01 || load_done !== 1'b1 || addr_q.size() != 0) begin
      errors++; $display("FAIL gap_exit got st %0h d%0b q%0d exp 1 1 0", stage, load_done, addr_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_one(1'b1);
    repeat (8) @(negedge clk);
    #1;
    checks++; if (stage !== 2'b11 || instr_count !== CNT_W'(2)) begin
      errors++; $display("FAIL ar_pre got st %0h cnt %0d exp 3 2", stage, instr_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (stage !== 2'b00 || instr_count !== '0 || halted !== 1'b0 || load_ready !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL ar_now got st %0h cnt %0d h%0b r%0b d%0b exp 0 0 0 1 0",
                         stage, instr_count, halted, load_ready, load_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    load_one(1'b1);
    for (int n = 0; n < 20; n++) begin
      exp_cnt = (n > 15) ? 15 : n;
      #1;
      checks++; if (stage !== 2'b01 || instr_count !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL sat_%0d got st %0h cnt %0d exp 1 %0d", n, stage, instr_count, exp_cnt); end
      repeat (3) @(negedge clk);
    end
    #1;
    checks++; if (instr_count !== CNT_W'(15)) begin errors++; $display("FAIL sat_final got %0d exp 15", instr_count); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_autoterm();
    test_halt_step();
    test_reload();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
